mac_sequencer: RTL and testbench

MAC_SEQUENCER -- requirements
Module: mac_sequencer

---
 rtl/mac_sequencer_pkg.sv | 19 +
 rtl/mac_sequencer.sv | 168 ++++++++++++++++
 tb/tb_mac_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_sequencer_pkg.sv
// Shared ALU opcode/width definitions and the MAC sequencer state encoding.
package mac_sequencer_pkg;

  localparam int unsigned REG_WORD_LEN = 16;
  localparam int unsigned ALU_MODE_LEN = 4;
  localparam int unsigned SHIFT_LEN    = 4;
  localparam int unsigned NTAPS_W      = 6;

  localparam logic [ALU_MODE_LEN-1:0] ALU_NOP = 4'h0;
  localparam logic [ALU_MODE_LEN-1:0] ALU_MAC = 4'h7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } mac_state_t;

endpackage

// File: rtl/mac_sequencer.sv
// Dot-product sequencer: walks coefficient ROM and circular sample RAM,
// drives an external Q15 MAC ALU and returns a saturated result.
module mac_sequencer
  import mac_sequencer_pkg::*;
#(
  parameter int unsigned WORD_LEN = REG_WORD_LEN,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned ACC_W    = WORD_LEN + 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NTAPS_W-1:0]      ntaps,
  input  logic [ADDR_W-1:0]       coef_base,
  input  logic [ADDR_W-1:0]       samp_base,
  output logic [ADDR_W-1:0]       coef_addr,
  input  logic [WORD_LEN-1:0]     coef_data,
  output logic [ADDR_W-1:0]       samp_addr,
  input  logic [WORD_LEN-1:0]     samp_data,
  output logic [ALU_MODE_LEN-1:0] alu_opcode,
  output logic [WORD_LEN-1:0]     alu_a,
  output logic [WORD_LEN-1:0]     alu_b,
  output logic [WORD_LEN-1:0]     alu_c,
  output logic [SHIFT_LEN-1:0]    alu_shift,
  input  logic [WORD_LEN-1:0]     alu_out,
  output logic                    busy,
  output logic                    done,
  output logic [WORD_LEN-1:0]     result,
  output logic                    sat
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'd1 << (WORD_LEN - 1)) - 64'd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  mac_state_t               state_q, state_d;
  logic [NTAPS_W-1:0]       idx_q, idx_d, idx_inc;
  logic signed [ACC_W-1:0]  acc_q, acc_d, acc_sum;
  logic [NTAPS_W-1:0]       ntaps_q;
  logic [ADDR_W-1:0]        coef_base_q, samp_base_q;
  logic [ADDR_W-1:0]        coef_addr_d, samp_addr_d;
  logic                     busy_d, done_d, sat_d;
  logic [WORD_LEN-1:0]      result_d;

  assign idx_inc = idx_q + NTAPS_W'(1);
  assign acc_sum = acc_q + {{(ACC_W - WORD_LEN){alu_out[WORD_LEN-1]}}, alu_out};

  // Next state, tap index, accumulator and registered-output values.
  always_comb begin : next_logic
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    coef_addr_d = '0;
    samp_addr_d = '0;
    done_d      = 1'b0;
    result_d    = result;
    sat_d       = sat;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (ntaps == '0) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = '0;
            sat_d    = 1'b0;
          end else begin
            state_d     = ST_PRIME;
            idx_d       = '0;
            acc_d       = '0;
            coef_addr_d = coef_base;
            samp_addr_d = samp_base;
          end
        end
      end
      ST_PRIME: begin
        state_d     = ST_RUN;
        idx_d       = idx_inc;
        acc_d       = '0;
        coef_addr_d = coef_base_q + ADDR_W'(idx_inc);
        samp_addr_d = samp_base_q - ADDR_W'(idx_inc);
      end
      ST_RUN: begin
        // Data for the tap fetched last cycle is on the ALU now.
        acc_d = acc_sum;
        if (idx_q == ntaps_q) begin
          state_d = ST_DONE;
          idx_d   = '0;
          done_d  = 1'b1;
          if (acc_sum > SAT_MAX) begin
            result_d = WORD_LEN'(SAT_MAX);
            sat_d    = 1'b1;
          end else if (acc_sum < SAT_MIN) begin
            result_d = WORD_LEN'(SAT_MIN);
            sat_d    = 1'b1;
          end else begin
            result_d = WORD_LEN'(acc_sum);
            sat_d    = 1'b0;
          end
        end else begin
          idx_d       = idx_inc;
          coef_addr_d = coef_base_q + ADDR_W'(idx_inc);
          samp_addr_d = samp_base_q - ADDR_W'(idx_inc);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin : state_reg
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      coef_addr <= '0;
      samp_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      sat       <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      coef_addr <= coef_addr_d;
      samp_addr <= samp_addr_d;
      busy      <= busy_d;
      done      <= done_d;
      result    <= result_d;
      sat       <= sat_d;
    end
  end

  // Job parameters captured only when a start is accepted.
  always_ff @(posedge clk) begin : job_reg
    if (rst) begin
      ntaps_q     <= '0;
      coef_base_q <= '0;
      samp_base_q <= '0;
    end else if ((state_q == ST_IDLE) && start) begin
      ntaps_q     <= ntaps;
      coef_base_q <= coef_base;
      samp_base_q <= samp_base;
    end
  end

  // ALU operands follow the memory read data while taps are streaming.
  always_comb begin : alu_drive
    alu_opcode = ALU_NOP;
    alu_a      = '0;
    alu_b      = '0;
    alu_c      = '0;
    if (state_q == ST_RUN) begin
      alu_opcode = ALU_MAC;
      alu_a      = coef_data;
      alu_b      = samp_data;
    end
  end

  assign alu_shift = '0;

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer with ROM/RAM/ALU models and a
// dot-product reference computed directly from memory contents.
module tb_mac_sequencer;
  import mac_sequencer_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [NTAPS_W-1:0] ntaps = '0;
  logic [AW-1:0] coef_base = '0, samp_base = '0;
  logic [AW-1:0] coef_addr, samp_addr;
  logic [W-1:0] coef_data = '0, samp_data = '0;
  logic [ALU_MODE_LEN-1:0] alu_opcode;
  logic [W-1:0] alu_a, alu_b, alu_c, alu_out;
  logic [SHIFT_LEN-1:0] alu_shift;
  logic busy, done, sat;
  logic [W-1:0] result;

  mac_sequencer #(.WORD_LEN(W), .ADDR_W(AW), .ACC_W(W + 5)) dut (
    .clk(clk), .rst(rst), .start(start), .ntaps(ntaps),
    .coef_base(coef_base), .samp_base(samp_base),
    .coef_addr(coef_addr), .coef_data(coef_data),
    .samp_addr(samp_addr), .samp_data(samp_data),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .alu_shift(alu_shift), .alu_out(alu_out),
    .busy(busy), .done(done), .result(result), .sat(sat)
  );

  always #5 clk = ~clk;

  logic [W-1:0] coef_mem [256];
  logic [W-1:0] samp_mem [256];

  // Synchronous-read memories: data appears the cycle after the address.
  always @(posedge clk) begin
    coef_data <= coef_mem[coef_addr];
    samp_data <= samp_mem[samp_addr];
  end

  function automatic logic [W-1:0] q15(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p[30:15];
  endfunction

  assign alu_out = (alu_opcode == ALU_MAC) ? q15(alu_a, alu_b) + alu_c : '0;

  typedef struct {
    int     res;
    bit     sat;
    longint due;
    int     blen;
  } exp_t;

  exp_t   sb_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc = 0;
  bit     mon_en = 1'b0;
  bit     job_active = 1'b0;
  longint job_t = 0;
  int     job_n = 0;
  int     job_cb = 0, job_sb = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain dot product over the circular buffers, then clamp.
  task automatic model(input int n, input int cb, input int sb, output int res, output bit s);
    longint acc;
    acc = 0;
    for (int k = 0; k < n; k++)
      acc += longint'($signed(q15(coef_mem[(cb + k) & 255], samp_mem[(sb - k) & 255])));
    s = 1'b0;
    if (acc > 32767) begin acc = 32767; s = 1'b1; end
    else if (acc < -32768) begin acc = -32768; s = 1'b1; end
    res = int'(acc);
  endtask

  // Monitor: pops expectations on done and checks address/idle behaviour.
  int busy_run = 0;
  bit prev_done = 1'b0;
  always @(negedge clk) begin : mon
    exp_t e;
    int k;
    if (mon_en) begin
      if (busy) busy_run++; else busy_run = 0;
      if (prev_done) chk("busy_after_done", busy, 0);
      chk("alu_c_zero", alu_c, 0);
      chk("alu_shift_zero", alu_shift, 0);
      if (!busy) begin
        chk("idle_coef_addr", coef_addr, 0);
        chk("idle_samp_addr", samp_addr, 0);
        chk("idle_opcode", alu_opcode, ALU_NOP);
      end
      if (job_active && cyc >= job_t + 1 && cyc <= job_t + job_n) begin
        k = int'(cyc - job_t - 1);
        chk("coef_addr", coef_addr, (job_cb + k) & 255);
        chk("samp_addr", samp_addr, (job_sb - k) & 255);
        chk(k == 0 ? "prime_opcode" : "run_opcode", alu_opcode, k == 0 ? ALU_NOP : ALU_MAC);
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
        end else begin
          e = sb_q.pop_front();
          chk("result", longint'($signed(result)), e.res);
          chk("sat", sat, e.sat);
          chk("done_cycle", cyc, e.due);
          chk("busy_cycles", busy_run, e.blen);
        end
      end
      prev_done = done;
    end
  end

  task automatic fill_const(input logic [W-1:0] c, input logic [W-1:0] s);
    for (int i = 0; i < 256; i++) begin
      coef_mem[i] = c;
      samp_mem[i] = s;
    end
  endtask

  task automatic fill_rand(input int mode);
    for (int i = 0; i < 256; i++) begin
      case (mode)
        1: begin
          coef_mem[i] = W'(32000 + $urandom_range(0, 767));
          samp_mem[i] = W'(32000 + $urandom_range(0, 767));
        end
        2: begin
          coef_mem[i] = W'(32000 + $urandom_range(0, 767));
          samp_mem[i] = W'(-32000 - int'($urandom_range(0, 768)));
        end
        default: begin
          coef_mem[i] = W'($urandom);
          samp_mem[i] = W'($urandom);
        end
      endcase
    end
  endtask

  // Issue one job from IDLE; noise 1 = random start/inputs while busy, 2 = start held high.
  task automatic run_job(input int n, input int cb, input int sb, input int noise,
                         input bit force_exp, input int fres, input bit fsat);
    exp_t e;
    int g;
    g = 0;
    while (busy) begin
      @(negedge clk);
      g++;
      if (g > 200) begin
        n_cmp++; n_bad++;
        $display("FAIL idle_wait: busy still 1 after %0d cycles, required 0", g);
        return;
      end
    end
    model(n, cb, sb, e.res, e.sat);
    if (force_exp) begin
      e.res = fres;
      e.sat = fsat;
    end
    e.due  = cyc + ((n == 0) ? 1 : n + 2);
    e.blen = (n == 0) ? 1 : n + 2;
    sb_q.push_back(e);
    job_t = cyc; job_n = n; job_cb = cb & 255; job_sb = sb & 255; job_active = 1'b1;
    start = 1'b1;
    ntaps = NTAPS_W'(n);
    coef_base = AW'(cb);
    samp_base = AW'(sb);
    @(negedge clk);
    start = 1'b0;
    g = 0;
    while (busy) begin
      if (noise == 1) start = 1'($urandom_range(0, 1));
      if (noise == 2) start = 1'b1;
      if (noise != 0) begin
        ntaps = NTAPS_W'($urandom_range(0, 32));
        coef_base = AW'($urandom);
        samp_base = AW'($urandom);
      end
      @(negedge clk);
      g++;
      if (g > 100) begin
        n_cmp++; n_bad++;
        $display("FAIL job_end: busy still 1 after %0d cycles, required 0", g);
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin : stim
    longint t;
    fill_rand(0);
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    chk("reset_sat", sat, 0);
    chk("reset_coef_addr", coef_addr, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Reset in the second RUN cycle aborts the job with no done.
    t = cyc;
    job_t = t; job_n = 4; job_cb = 3; job_sb = 9; job_active = 1'b1;
    start = 1'b1; ntaps = 6'd4; coef_base = 8'd3; samp_base = 8'd9;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; job_active = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_sat", sat, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    fill_const(16'd16384, 16'd16384);
    run_job(2, 10, 20, 0, 1'b1, 16384, 1'b0);
    fill_const(16'd32767, 16'd32767);
    run_job(4, 0, 0, 0, 1'b1, 32767, 1'b1);
    fill_const(16'h8000, 16'd32767);
    run_job(4, 100, 7, 0, 1'b1, -32768, 1'b1);
    fill_rand(0);
    run_job(3, 250, 1, 0, 1'b0, 0, 1'b0);
    run_job(0, 5, 5, 0, 1'b1, 0, 1'b0);
    run_job(32, 17, 3, 2, 1'b0, 0, 1'b0);
    run_job(0, 1, 2, 2, 1'b1, 0, 1'b0);
    fill_rand(1);
    run_job(1, 40, 40, 1, 1'b0, 0, 1'b0);

    for (int j = 0; j < 40; j++) begin
      if ($urandom_range(0, 3) == 0) fill_rand(int'($urandom_range(0, 2)));
      run_job(int'($urandom_range(0, 32)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 2)), 1'b0, 0, 1'b0);
    end

    repeat (10) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule
